// File: rtl/qcl_address_generator.sv
// qcl_address_generator: command-driven burst address generator with optional aligned-window wrap.
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   cmd_v_i / cmd_ready_o          command handshake (accepted only in IDLE)
//   base_i, stride_i, len_i        burst start address, per-beat increment, beat count
//   wrap_en_i, wrap_lg_i           wrap inside an aligned 2^wrap_lg_i window
//   addr_o, v_o, ready_i, last_o   address stream handshake, last marks the final beat
//   done_o                         one-cycle pulse after the last beat transfers
//   busy_o                         burst (or its done cycle) in progress
module qcl_address_generator #(
    parameter int addr_width_p    = 16,
    parameter int len_width_p     = 8,
    parameter int wrap_lg_width_p = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    input  logic [addr_width_p-1:0]    base_i,
    input  logic [addr_width_p-1:0]    stride_i,
    input  logic [len_width_p-1:0]     len_i,
    input  logic                       wrap_en_i,
    input  logic [wrap_lg_width_p-1:0] wrap_lg_i,
    output logic [addr_width_p-1:0]    addr_o,
    output logic                       v_o,
    input  logic                       ready_i,
    output logic                       last_o,
    output logic                       done_o,
    output logic                       busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e                     state_q;
    logic [addr_width_p-1:0]    base_q, stride_q, offset_q, offset_d, addr_q, addr_d, sum_d, mask_d;
    logic [len_width_p-1:0]     rem_q;
    logic                       wrap_en_q, v_q, last_q, done_q;
    logic [wrap_lg_width_p-1:0] wrap_lg_q, lg_d;
    // Address for the beat after the current one; registered so addr_o is glitch-free.
    // The mask is built one bit wider so a window equal to the full address width yields all ones.
    always_comb begin
        lg_d     = (32'(wrap_lg_q) > 32'(addr_width_p)) ? wrap_lg_width_p'(addr_width_p) : wrap_lg_q;
        mask_d   = addr_width_p'(((addr_width_p+1)'(1) << lg_d) - (addr_width_p+1)'(1));
        offset_d = offset_q + stride_q;
        sum_d    = base_q + offset_d;
        addr_d   = wrap_en_q ? ((base_q & ~mask_d) | (sum_d & mask_d)) : sum_d;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            base_q    <= '0;
            stride_q  <= '0;
            offset_q  <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            wrap_en_q <= 1'b0;
            wrap_lg_q <= '0;
            v_q       <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cmd_v_i) begin
                    base_q    <= base_i;
                    stride_q  <= stride_i;
                    offset_q  <= '0;
                    addr_q    <= base_i;
                    rem_q     <= len_i;
                    wrap_en_q <= wrap_en_i;
                    wrap_lg_q <= wrap_lg_i;
                    state_q   <= (len_i != '0) ? RUN : DONE;
                    v_q       <= (len_i != '0);
                    last_q    <= (len_i == len_width_p'(1));
                    done_q    <= (len_i == '0);
                end
                RUN: if (ready_i) begin
                    offset_q <= offset_d;
                    addr_q   <= addr_d;
                    rem_q    <= rem_q - len_width_p'(1);
                    last_q   <= (rem_q == len_width_p'(2));
                    if (last_q) begin
                        state_q <= DONE;
                        v_q     <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign addr_o      = addr_q;
    assign v_o         = v_q;
    assign last_o      = last_q;
    assign done_o      = done_q;
    assert property (@(posedge clk_i) disable iff (reset_i)
        v_o && !ready_i |=> v_o && $stable(addr_o) && $stable(last_o));
    assert property (@(posedge clk_i) disable iff (reset_i) done_o |=> !done_o);
endmodule

// File: tb/tb_qcl_address_generator.sv
// tb_qcl_address_generator: directed bench for qcl_address_generator (16-bit and 8-bit instances).
module tb_qcl_address_generator;
    logic        clk_i = 1'b0, reset_i = 1'b1, cmd_v_i = 1'b0, ready_i = 1'b1;
    logic [15:0] base_i = '0, stride_i = '0;
    logic [7:0]  len_i = '0;
    logic        wrap_en_i = 1'b0;
    logic [4:0]  wrap_lg_i = '0;
    logic [15:0] addr_o;
    logic        cmd_ready_o, v_o, last_o, done_o, busy_o;
    logic [7:0]  a8_o;
    logic        r8_o, v8_o, l8_o, d8_o, b8_o;
    int          n_chk = 0, n_fail = 0;
    logic [15:0] exp_q[$];

    qcl_address_generator #(.addr_width_p(16), .len_width_p(8), .wrap_lg_width_p(5)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
        .base_i(base_i), .stride_i(stride_i), .len_i(len_i), .wrap_en_i(wrap_en_i),
        .wrap_lg_i(wrap_lg_i), .addr_o(addr_o), .v_o(v_o), .ready_i(ready_i),
        .last_o(last_o), .done_o(done_o), .busy_o(busy_o));

    qcl_address_generator #(.addr_width_p(8), .len_width_p(8), .wrap_lg_width_p(5)) dut8 (
        .clk_i(clk_i), .reset_i(reset_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(r8_o),
        .base_i(base_i[7:0]), .stride_i(stride_i[7:0]), .len_i(len_i), .wrap_en_i(wrap_en_i),
        .wrap_lg_i(wrap_lg_i), .addr_o(a8_o), .v_o(v8_o), .ready_i(ready_i),
        .last_o(l8_o), .done_o(d8_o), .busy_o(b8_o));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [15:0] b, input logic [15:0] s, input logic [7:0] l,
                        input logic we, input logic [4:0] wl, input bit keep);
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_v_i = 1'b1; base_i = b; stride_i = s; len_i = l; wrap_en_i = we; wrap_lg_i = wl;
        tick();
        cmd_v_i = keep;
        if (!keep) begin
            base_i = 16'hDEAD; stride_i = 16'h0777; len_i = 8'hEE; wrap_lg_i = 5'd3;
        end
    endtask

    task automatic collect(input bit bp, input bit chk8);
        int n = 0, cyc = 0;
        int total = exp_q.size();
        logic hold = 1'b0, pl = 1'b0;
        logic [15:0] pa = '0, e;
        while (exp_q.size() > 0 && cyc < 200) begin
            ready_i = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (cyc == 0) chk("latency_v", v_o, 1);
            if (hold) begin
                chk("hold_addr", addr_o, pa);
                chk("hold_last", last_o, pl);
            end
            chk("busy_run", busy_o, 1);
            chk("cmd_ready_run", cmd_ready_o, 0);
            if (v_o && ready_i) begin
                e = exp_q.pop_front();
                chk("addr", addr_o, e);
                chk("last", last_o, exp_q.size() == 0);
                if (chk8) chk("addr8", a8_o, e[7:0]);
                n++;
            end
            hold = v_o && !ready_i; pa = addr_o; pl = last_o;
            tick();
            cyc++;
        end
        exp_q.delete();
        ready_i = 1'b1;
        chk("beats", n, total);
        chk("done_pulse", done_o, 1);
        chk("v_after_last", v_o, 0);
        tick();
        chk("done_one_cycle", done_o, 0);
        chk("cmd_ready_after", cmd_ready_o, 1);
        chk("busy_after", busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk("rst_v", v_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        reset_i = 1'b0;
        tick();
        // linear burst, full throughput
        send(16'h0100, 16'h0004, 8'd4, 1'b0, 5'd0, 1'b0);
        exp_q = '{16'h0100, 16'h0104, 16'h0108, 16'h010C};
        collect(1'b0, 1'b1);
        // same burst under backpressure
        send(16'h0100, 16'h0004, 8'd4, 1'b0, 5'd0, 1'b0);
        exp_q = '{16'h0100, 16'h0104, 16'h0108, 16'h010C};
        collect(1'b1, 1'b1);
        // wrap inside 16-byte window
        send(16'h001C, 16'h0004, 8'd4, 1'b1, 5'd4, 1'b0);
        exp_q = '{16'h001C, 16'h0010, 16'h0014, 16'h0018};
        collect(1'b0, 1'b0);
        // window of size 1 pins the address to base
        send(16'h0123, 16'h0005, 8'd3, 1'b1, 5'd0, 1'b0);
        exp_q = '{16'h0123, 16'h0123, 16'h0123};
        collect(1'b0, 1'b0);
        // oversized window clamps to full width, behaving linearly
        send(16'hFFF8, 16'h0008, 8'd2, 1'b1, 5'd31, 1'b0);
        exp_q = '{16'hFFF8, 16'h0000};
        collect(1'b0, 1'b0);
        // zero-length command: done next cycle, no beats
        send(16'h0040, 16'h0001, 8'd0, 1'b0, 5'd0, 1'b0);
        chk("len0_v", v_o, 0);
        chk("len0_done", done_o, 1);
        chk("len0_busy", busy_o, 1);
        tick();
        chk("len0_done_once", done_o, 0);
        chk("len0_ready", cmd_ready_o, 1);
        // single beat
        send(16'h0055, 16'h0003, 8'd1, 1'b0, 5'd0, 1'b0);
        exp_q = '{16'h0055};
        collect(1'b0, 1'b1);
        // negative stride from zero (also checked on the 8-bit instance)
        send(16'h0000, 16'hFFFF, 8'd3, 1'b0, 5'd0, 1'b0);
        exp_q = '{16'h0000, 16'hFFFF, 16'hFFFE};
        collect(1'b0, 1'b1);
        // overflow wraps silently
        send(16'hFFF0, 16'h0010, 8'd2, 1'b0, 5'd0, 1'b0);
        exp_q = '{16'hFFF0, 16'h0000};
        collect(1'b0, 1'b1);
        // command held while busy; params changed mid-burst are ignored
        send(16'h0200, 16'h0002, 8'd3, 1'b0, 5'd0, 1'b1);
        base_i = 16'h0300; stride_i = 16'h0010; len_i = 8'd2;
        exp_q = '{16'h0200, 16'h0202, 16'h0204};
        collect(1'b0, 1'b1);
        tick();
        cmd_v_i = 1'b0;
        exp_q = '{16'h0300, 16'h0310};
        collect(1'b0, 1'b1);
        // async reset after 2 of 5 beats
        send(16'h0400, 16'h0008, 8'd5, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        chk("pre_rst_addr", addr_o, 16'h0410);
        #2 reset_i = 1'b1;
        #1;
        chk("mid_rst_v", v_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ready", cmd_ready_o, 1);
        chk("mid_rst_done", done_o, 0);
        #2 reset_i = 1'b0;
        tick();
        chk("post_rst_done", done_o, 0);
        tick();
        chk("post_rst_done2", done_o, 0);
        send(16'h0500, 16'h0001, 8'd2, 1'b0, 5'd0, 1'b0);
        exp_q = '{16'h0500, 16'h0501};
        collect(1'b0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
